// File: rtl/packetram_unaligned.sv
// rtl/packetram_unaligned.sv - packet buffer with unaligned big-endian byte/half/word loads
// Optional macro PACKETRAM_RD_OOB_EN enables out-of-bounds load detection.
module packetram_unaligned #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    localparam int BYTES = DATA_WIDTH / 8,
    localparam int OFFW  = $clog2(BYTES),
    localparam int LW    = ADDR_WIDTH + OFFW + 1
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       wr_start_i,
    input  logic                       wr_en_i,
    input  logic [DATA_WIDTH-1:0]      wr_data_i,
    input  logic                       wr_last_i,
    input  logic [OFFW-1:0]            wr_bytes_i,
    output logic                       pkt_ready_o,
    output logic [LW-1:0]              pkt_len_o,
    output logic                       wr_ovf_o,
    input  logic                       rd_en_i,
    input  logic [ADDR_WIDTH+OFFW-1:0] rd_addr_i,
    input  logic [1:0]                 rd_size_i,
    output logic [DATA_WIDTH-1:0]      rd_data_o,
    output logic                       rd_valid_o,
    output logic                       rd_oob_o
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [2:0] WORD_N = (BYTES >= 4) ? 3'd4 : 3'd2;

    typedef enum logic [1:0] {EMPTY, FILL, READY} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH:0]     ptr_q, ptr_d;
    logic [LW-1:0]           len_q, len_d;
    logic                    ovf_q, ovf_d;
    logic                    ram_we;
    logic                    full;
    logic [LW-1:0]           last_bytes;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [DATA_WIDTH-1:0]   ram_a_q, ram_b_q;
    logic [ADDR_WIDTH-1:0]   rd_a, rd_b;
    logic [2:0]              n_d, n1_q;
    logic [OFFW-1:0]         off1_q;
    logic                    valid1_q;
    logic                    oob_d, oob1_q;

    logic [DATA_WIDTH-1:0]   top_word, shifted;
    logic [OFFW:0]           idx;
    logic [OFFW+3:0]         shr;
    int                      bi;

    logic [DATA_WIDTH-1:0]   rd_data_q;
    logic                    rd_valid_q, rd_oob_q;

    // Fill FSM: state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= EMPTY;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (wr_start_i)
            state_d = FILL;
        else if (state_q == FILL && wr_en_i && wr_last_i)
            state_d = READY;
    end

    always_comb begin
        pkt_ready_o = (state_q == READY);
        ram_we      = (state_q == FILL) && wr_en_i && !wr_start_i && !full;
    end

    assign full       = (ptr_q == (ADDR_WIDTH+1)'(DEPTH));
    assign last_bytes = (wr_bytes_i == '0) ? LW'(BYTES) : LW'(wr_bytes_i);

    always_comb begin
        ptr_d = ptr_q;
        len_d = len_q;
        ovf_d = ovf_q;
        if (wr_start_i) begin
            ptr_d = '0;
            len_d = '0;
            ovf_d = 1'b0;
        end else if (state_q == FILL && wr_en_i) begin
            if (!full) begin
                ptr_d = ptr_q + 1'b1;
                if (wr_last_i) len_d = {ptr_q, {OFFW{1'b0}}} + last_bytes;
            end else if (wr_last_i) begin
                len_d = {ptr_q, {OFFW{1'b0}}};
            end else begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q <= '0;
            len_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
            len_q <= len_d;
            ovf_q <= ovf_d;
        end
    end

    assign pkt_len_o = len_q;
    assign wr_ovf_o  = ovf_q;

    // Dual-port read of the two spanning words; last word wraps to word 0
    assign rd_a = rd_addr_i[ADDR_WIDTH+OFFW-1:OFFW];
    assign rd_b = rd_a + ADDR_WIDTH'(1);

    always_ff @(posedge clk_i) begin
        if (ram_we) mem[ptr_q[ADDR_WIDTH-1:0]] <= wr_data_i;
        ram_a_q <= mem[rd_a];
        ram_b_q <= mem[rd_b];
    end

    always_comb begin
        case (rd_size_i)
            2'd0:    n_d = 3'd1;
            2'd1:    n_d = 3'd2;
            default: n_d = WORD_N;
        endcase
    end

`ifdef PACKETRAM_RD_OOB_EN
    assign oob_d = (state_q != READY) || ((LW'(rd_addr_i) + LW'(n_d)) > len_q);
`else
    assign oob_d = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid1_q <= 1'b0;
            oob1_q   <= 1'b0;
            off1_q   <= '0;
            n1_q     <= 3'd1;
        end else begin
            valid1_q <= rd_en_i;
            oob1_q   <= oob_d;
            off1_q   <= rd_addr_i[OFFW-1:0];
            n1_q     <= n_d;
        end
    end

    // Funnel: byte i of the window is byte (off+i) of {word a, word b}
    always_comb begin
        top_word = '0;
        idx      = '0;
        bi       = 0;
        for (int i = 0; i < BYTES; i++) begin
            idx = (OFFW+1)'(off1_q) + (OFFW+1)'(i);
            bi  = int'(idx[OFFW-1:0]);
            top_word[DATA_WIDTH-1-8*i -: 8] = idx[OFFW] ? ram_b_q[DATA_WIDTH-1-8*bi -: 8]
                                                        : ram_a_q[DATA_WIDTH-1-8*bi -: 8];
        end
        shr     = {(OFFW+1)'(BYTES) - (OFFW+1)'(n1_q), 3'b000};
        shifted = top_word >> shr;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            rd_oob_q   <= 1'b0;
        end else begin
            rd_data_q  <= oob1_q ? '0 : shifted;
            rd_valid_q <= valid1_q;
            rd_oob_q   <= oob1_q;
        end
    end

    assign rd_data_o  = rd_data_q;
    assign rd_valid_o = rd_valid_q;
    assign rd_oob_o   = rd_oob_q;

endmodule

// File: doc/packetram_unaligned.md
# packetram_unaligned

Parametrised packet buffer for the BPF core that stores an incoming packet word by word and serves single-request unaligned big-endian byte, half-word and word loads at any byte address. It reads both spanning words through a dual-port BRAM read and funnel-shifts them. It adds a fill state machine, a byte-length register and optional out-of-bounds detection. It sits between the packet ingest path (write side) and the BPF CPU load unit (read side).

## Interface
- ADDR_WIDTH, 10, word-address width; DEPTH = 2**ADDR_WIDTH words
- DATA_WIDTH, 32, word width; multiple of 8, at least 16; BYTES = DATA_WIDTH/8 (power of two); OFFW = clog2(BYTES)
- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- wr_start  in  1  begin new packet: pointer and length cleared
- wr_en  in  1  write wr_data at current write pointer
- wr_data  in  DATA_WIDTH  packet word, byte 0 in MSBs (network order)
- wr_last  in  1  qualifies wr_en: final word of packet
- wr_bytes  in  OFFW  valid bytes in final word; 0 means BYTES
- pkt_ready  out  1  packet complete and readable
- pkt_len  out  ADDR_WIDTH+OFFW+1  stored length in bytes
- wr_ovf  out  1  sticky: write dropped because buffer full
- rd_en  in  1  load request
- rd_addr  in  ADDR_WIDTH+OFFW  byte address
- rd_size  in  2  0 byte, 1 half-word, 2 word (32 bits), 3 reserved, treated as 2
- rd_data  out  DATA_WIDTH  result, right-aligned, zero-extended
- rd_valid  out  1  rd_data valid for one cycle
- rd_oob  out  1  load exceeded pkt_len; same cycle as rd_valid

## Operation
- Fill FSM states: EMPTY, FILL, READY. Reset and idle state is EMPTY.
- wr_start in any state goes to FILL, clears the pointer, pkt_len, wr_ovf and pkt_ready. wr_start has priority over a same-cycle wr_en.
- FILL with wr_en: write RAM[ptr] and increment ptr. If wr_last is also high, set pkt_len = ptr*BYTES + (wr_bytes==0 ? BYTES : wr_bytes) and go to READY.
- When ptr == DEPTH, further non-last writes are dropped and set wr_ovf. A dropped write with wr_last goes to READY with pkt_len = DEPTH*BYTES.
- wr_en is ignored in EMPTY and READY.
- Reads are accepted in every state, one per cycle, fully pipelined.
- Word index a = rd_addr >> OFFW, b = a+1 mod DEPTH; the last word wraps to word 0. Offset o = rd_addr[OFFW-1:0].
- Concatenate {RAM[a], RAM[b]}, select the n = 1/2/4 bytes starting at byte o, and place them big-endian at LSBs. Upper bits are 0.
- RAM is read-first: a read of a word written in the same cycle returns old data.

## Timing
- Write: RAM updated at the edge where wr_en is sampled. pkt_ready and pkt_len update on the same edge as the last write.
- Read latency is 2. rd_en sampled at edge N: RAM registers at N+1, then rd_data/rd_valid/rd_oob registered at N+2.
- rd_valid is a pure pipeline of rd_en with no backpressure.
- Reset values: state EMPTY, ptr 0, pkt_len 0, pkt_ready 0, wr_ovf 0, rd_valid 0, rd_oob 0, rd_data 0. RAM contents are not reset.
- Reset mid-read flushes the pipeline; no rd_valid follows.
- Reset mid-fill discards the packet.

## Configuration
- PACKETRAM_RD_OOB_EN defined: OOB is computed in stage 1. A load is OOB when rd_addr + n > pkt_len, or when state is not READY. On an OOB load rd_oob=1 and rd_data=0.
- PACKETRAM_RD_OOB_EN undefined: rd_oob is tied 0 and raw shifted data is always returned, including wrapped reads.

## Test plan
- ADDR_WIDTH=4, DATA_WIDTH=32. wr_start, then write 0x00112233, 0x44556677, 0x8899AABB; last word with wr_bytes=2 -> pkt_ready=1, pkt_len=10.
- Aligned and unaligned reads on that packet:
  - word @0 -> 0x00112233
  - word @3 -> 0x33445566
  - half @7 -> 0x00007788
  - byte @9 -> 0x00000099
  - each with rd_valid exactly 2 cycles after rd_en.
- Back-to-back reads on 4 consecutive cycles -> 4 consecutive rd_valid with results in order.
- With PACKETRAM_RD_OOB_EN: word @8 on the 10-byte packet -> rd_oob=1, rd_data=0. half @8 -> rd_oob=0, rd_data=0x00008899.
- Overflow and wrap:
  - Write 16 words 0x0..0xF (none last), then 1 more -> wr_ovf=1, RAM[0] unchanged.
  - wr_last write -> pkt_len=64.
  - Word @62 (macro undefined) -> bytes of word 15 [2:3] followed by word 0 [0:1].
- Assert rst between rd_en and rd_valid -> rd_valid stays 0. After reset pkt_ready=0, and with the macro defined a subsequent read -> rd_oob=1.
